// File: rtl/eth_pkg.sv
// Shared Ethernet TX framing constants and the framer state encoding.
// Used by the preamble/SFD inserter and its CRC helper.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_PAYLOAD,
    S_FCS,
    S_IFG
  } tx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte reflected CRC-32 update, purely combinational.
// Only instantiated when PREAMBLE_INSERT_FCS_EN is defined.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    o_crc = i_crc ^ {24'd0, i_data};
    for (int i = 0; i < 8; i++) begin
      o_crc = o_crc[0] ? ((o_crc >> 1) ^ CRC32_POLY)
                       : (o_crc >> 1);
    end
  end

endmodule

// File: rtl/preamble_sfd_inserter.sv
// Byte-wide TX framer: preamble, SFD, payload, optional FCS, IFG.
// Define PREAMBLE_INSERT_FCS_EN to append a CRC-32 FCS to each frame.
module preamble_sfd_inserter
  import eth_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              tx_busy,
  output logic              underrun_err,
  output logic [15:0]       frame_count
);

  if (DATA_W != 8) begin : g_bad_width
    $error("preamble_sfd_inserter: DATA_W must be 8");
  end

  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 7) begin : g_bad_pre
    $error("preamble_sfd_inserter: PREAMBLE_LEN must be 1..7");
  end

  localparam int IFG_W =
    (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [2:0] PRE_LAST = 3'(PREAMBLE_LEN - 1);
  localparam logic [IFG_W-1:0] IFG_LAST =
    IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam tx_state_t S_AFTER =
    (IFG_CYCLES == 0) ? S_IDLE : S_IFG;

  tx_state_t        r_state;
  tx_state_t        w_next;
  logic [2:0]       r_pre_cnt;
  logic [IFG_W-1:0] r_ifg_cnt;
  logic [15:0]      r_frame_count;
  logic             w_accept;

`ifdef PREAMBLE_INSERT_FCS_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_next;
  logic [31:0] w_fcs;
  logic [1:0]  r_fcs_cnt;

  eth_crc32_byte u_crc (
    .i_crc  (r_crc),
    .i_data (s_axis_tdata),
    .o_crc  (w_crc_next)
  );

  assign w_fcs = ~r_crc;
`endif

  assign w_accept    = m_axis_tvalid & m_axis_tready;
  assign tx_busy     = (r_state != S_IDLE);
  assign frame_count = r_frame_count;

  always_comb begin
    w_next        = r_state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    underrun_err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (s_axis_tvalid) w_next = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = PREAMBLE_BYTE;
        if (m_axis_tready && r_pre_cnt == PRE_LAST)
          w_next = S_SFD;
      end
      S_SFD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = SFD_BYTE;
        if (m_axis_tready) w_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        underrun_err  = m_axis_tready & ~s_axis_tvalid;
`ifdef PREAMBLE_INSERT_FCS_EN
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast)
          w_next = S_FCS;
`else
        m_axis_tlast = s_axis_tlast & s_axis_tvalid;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast)
          w_next = S_AFTER;
`endif
      end
`ifdef PREAMBLE_INSERT_FCS_EN
      S_FCS: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = w_fcs[{r_fcs_cnt, 3'b000} +: 8];
        m_axis_tlast  = (r_fcs_cnt == 2'd3);
        if (m_axis_tready && r_fcs_cnt == 2'd3)
          w_next = S_AFTER;
      end
`endif
      S_IFG: begin
        if (r_ifg_cnt == IFG_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= S_IDLE;
      r_pre_cnt     <= '0;
      r_ifg_cnt     <= '0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != S_PREAMBLE)
        r_pre_cnt <= '0;
      else if (w_accept)
        r_pre_cnt <= r_pre_cnt + 3'd1;
      if (r_state != S_IFG)
        r_ifg_cnt <= '0;
      else
        r_ifg_cnt <= r_ifg_cnt + IFG_W'(1);
      if (w_accept && m_axis_tlast)
        r_frame_count <= r_frame_count + 16'd1;
    end
  end

`ifdef PREAMBLE_INSERT_FCS_EN
  // CRC reseeds while idle so every frame starts clean.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_crc     <= CRC32_INIT;
      r_fcs_cnt <= '0;
    end else begin
      if (r_state == S_IDLE)
        r_crc <= CRC32_INIT;
      else if (r_state == S_PAYLOAD && w_accept)
        r_crc <= w_crc_next;
      if (r_state != S_FCS)
        r_fcs_cnt <= '0;
      else if (w_accept)
        r_fcs_cnt <= r_fcs_cnt + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_preamble_sfd_inserter.sv
// Self-checking bench for preamble_sfd_inserter.
// Honours PREAMBLE_INSERT_FCS_EN when building expected line bytes.
module tb_preamble_sfd_inserter;

  localparam int PL  = 7;
  localparam int IFG = 12;
  localparam int PL1 = 3;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  s_data, m_data;
  logic        s_valid, s_last, s_ready;
  logic        m_valid, m_last, m_ready;
  logic        busy, uerr;
  logic [15:0] fcnt;

  logic [7:0]  s1_data, m1_data;
  logic        s1_valid, s1_last, s1_ready;
  logic        m1_valid, m1_last, m1_ready;
  logic        busy1, uerr1;
  logic [15:0] fcnt1;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] fcnt_exp = '0;

  preamble_sfd_inserter dut0 (
    .aclk          (clk),
    .areset        (rst),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tlast  (m_last),
    .m_axis_tready (m_ready),
    .tx_busy       (busy),
    .underrun_err  (uerr),
    .frame_count   (fcnt)
  );

  preamble_sfd_inserter #(
    .PREAMBLE_LEN (PL1),
    .IFG_CYCLES   (0)
  ) dut1 (
    .aclk          (clk),
    .areset        (rst),
    .s_axis_tdata  (s1_data),
    .s_axis_tvalid (s1_valid),
    .s_axis_tlast  (s1_last),
    .s_axis_tready (s1_ready),
    .m_axis_tdata  (m1_data),
    .m_axis_tvalid (m1_valid),
    .m_axis_tlast  (m1_last),
    .m_axis_tready (m1_ready),
    .tx_busy       (busy1),
    .underrun_err  (uerr1),
    .frame_count   (fcnt1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t d);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'd0, d[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t line_of(input bq_t pl, input int plen);
    bq_t l;
    logic [31:0] c;
    l = {};
    repeat (plen) l.push_back(8'h55);
    l.push_back(8'hD5);
    foreach (pl[i]) l.push_back(pl[i]);
    c = crc32(pl);
`ifdef PREAMBLE_INSERT_FCS_EN
    for (int k = 0; k < 4; k++) l.push_back(c[8*k +: 8]);
`endif
    return l;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    q = {};
    repeat (n) q.push_back(8'($urandom));
    return q;
  endfunction

  // mode 0: ready held, 1: ready toggles, 2: two-cycle source bubble
  task automatic run_frame(input bq_t pl, input int mode);
    bq_t exp_l, got;
    int si, cyc, first, n, bub_left, nuerr;
    logic stall_prev, in_pay;
    logic [7:0] hold_d;
    exp_l = line_of(pl, PL);
    got = {};
    n = pl.size();
    si = 0; cyc = 0; first = -1;
    bub_left = 2; nuerr = 0;
    stall_prev = 1'b0; hold_d = '0;
    while (got.size() < exp_l.size() && cyc < 1000) begin
      m_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (mode == 2 && si == n / 2 && bub_left > 0) begin
        s_valid = 1'b0;
        bub_left--;
      end else begin
        s_valid = (si < n);
      end
      s_data = (si < n) ? pl[si] : 8'h00;
      s_last = (si == n - 1);
      @(negedge clk);
      in_pay = (got.size() >= PL + 1) && (got.size() < PL + 1 + n);
      if (stall_prev) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 32'(hold_d));
      end
      chk("s_ready", 32'(s_ready), 32'(in_pay & m_ready));
      chk("underrun", 32'(uerr), 32'(in_pay & m_ready & ~s_valid));
      if (first < 0 && m_valid) first = cyc;
      if (m_valid && m_ready) begin
        chk("tlast", 32'(m_last),
            32'(got.size() == exp_l.size() - 1));
        got.push_back(m_data);
      end
      stall_prev = m_valid & ~m_ready;
      hold_d = m_data;
      if (s_valid && s_ready) si++;
      nuerr += int'(uerr);
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("line_len", got.size(), exp_l.size());
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_l[i]));
    chk("first_valid_cycle", first, 1);
    fcnt_exp++;
    chk("frame_count", 32'(fcnt), 32'(fcnt_exp));
    if (mode == 2) chk("underrun_pulses", nuerr, 2);
    for (int g = 0; g < IFG; g++) begin
      m_ready = 1'($urandom);
      @(negedge clk);
      chk("ifg_valid", 32'(m_valid), 0);
      chk("ifg_busy", 32'(busy), 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bq_t pl, fa, fb, src, la, lb;
    logic [9:0] ew[$];
    int si1;

    rst = 1'b1;
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1; m_ready = 1'b1;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0; m1_ready = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_uerr", 32'(uerr), 0);
    chk("rst_fcnt", 32'(fcnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #1;

    run_frame(rand_bytes(64), 0);

    pl = {};
    for (int k = 0; k < 9; k++) pl.push_back(8'(8'h31 + k));
    run_frame(pl, 0);

    run_frame(rand_bytes(20), 1);
    run_frame(rand_bytes(16), 2);
    run_frame(rand_bytes(1), 0);

    // back-to-back frames on the short-preamble, zero-gap instance
    fa = rand_bytes(2);
    fb = rand_bytes(3);
    src = {fa, fb};
    la = line_of(fa, PL1);
    lb = line_of(fb, PL1);
    ew = {};
    ew.push_back(10'h000);
    foreach (la[i])
      ew.push_back({1'b1, 1'(i == la.size() - 1), la[i]});
    ew.push_back(10'h000);
    foreach (lb[i])
      ew.push_back({1'b1, 1'(i == lb.size() - 1), lb[i]});
    ew.push_back(10'h000);
    ew.push_back(10'h000);
    si1 = 0;
    foreach (ew[c]) begin
      s1_valid = (si1 < src.size());
      s1_data = (si1 < src.size()) ? src[si1] : 8'h00;
      s1_last = (si1 == fa.size() - 1) || (si1 == src.size() - 1);
      @(negedge clk);
      if (ew[c][9])
        chk($sformatf("b2b_c%0d", c),
            32'({m1_valid, m1_last, m1_data}), 32'(ew[c]));
      else
        chk($sformatf("b2b_gap_c%0d", c), 32'(m1_valid), 0);
      if (s1_valid && s1_ready) si1++;
      @(posedge clk); #1;
    end
    s1_valid = 1'b0;
    chk("b2b_frame_count", 32'(fcnt1), 2);

    // reset while payload is flowing
    s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b1;
    s_data = 8'($urandom);
    repeat (PL + 4) begin
      @(posedge clk); #1;
      s_data = 8'($urandom);
    end
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_s_ready", 32'(s_ready), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    chk("mid_rst_m_data", 32'(m_data), 0);
    chk("mid_rst_m_last", 32'(m_last), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_fcnt", 32'(fcnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
    fcnt_exp = '0;
    @(posedge clk); #1;
    run_frame(rand_bytes(10), 0);

    // preload the counter one short of wrapping
    dut0.r_frame_count = 16'hFFFF;
    fcnt_exp = 16'hFFFF;
    @(posedge clk); #1;
    run_frame(rand_bytes(8), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
